// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x8 lab-board key matrix scanner.
package keypad_pkg;

  localparam int NUM_ROWS     = 4;
  localparam int NUM_COLS     = 8;
  localparam int SCAN_DIV_DEF = 8000;  // 1 ms row slot at 8 MHz
  localparam int DEBOUNCE_DEF = 4;

  // Index of the currently driven matrix row (0..3, wraps naturally).
  typedef logic [1:0] row_idx_t;

endpackage

// File: rtl/keypad_row_debounce.sv
// Debounce for one matrix row: tracks a candidate vector and how many
// consecutive samples agreed with it, and commits the candidate to the
// output once the run length reaches DEBOUNCE_SCANS.
module keypad_row_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_en,
  input  logic [NUM_COLS-1:0] sample,
  output logic [NUM_COLS-1:0] key_row,
  output logic                changed
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_SCANS);

  logic [NUM_COLS-1:0] cand;
  logic [NUM_COLS-1:0] cand_next;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic                update;

  // Next candidate/run length if this cycle carries a sample; a differing
  // sample restarts the run at 1 so bounce never reaches the threshold.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (sample != cand) begin
      cand_next = sample;
      cnt_next  = CW'(1);
    end else if (cnt < DEB_MAX) begin
      cnt_next = cnt + 1'b1;
    end
    update = sample_en && (cnt_next == DEB_MAX) && (cand_next != key_row);
  end

  // Debounce state and output register; changed is a single-cycle strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand    <= '0;
      cnt     <= '0;
      key_row <= '0;
      changed <= 1'b0;
    end else begin
      changed <= update;
      if (sample_en) begin
        cand <= cand_next;
        cnt  <= cnt_next;
      end
      if (update) begin
        key_row <= cand_next;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning key matrix reader: drives one row low per slot, samples the
// synchronized columns at the end of the slot and debounces each row.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_COLS-1:0] col_in_n,
  output logic [NUM_ROWS-1:0] row_drive_n,
  output logic [NUM_COLS-1:0] key_row1,
  output logic [NUM_COLS-1:0] key_row2,
  output logic [NUM_COLS-1:0] key_row3,
  output logic [NUM_COLS-1:0] key_row4,
  output logic                key_change
);

  localparam int            SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [NUM_COLS-1:0] sync_meta;
  logic [NUM_COLS-1:0] sync_cols;
  logic [SW-1:0]       slot_cnt;
  row_idx_t            row_idx;
  logic                slot_wrap;
  logic [NUM_COLS-1:0] sample;

  logic [NUM_ROWS-1:0]               sample_en;
  logic [NUM_ROWS-1:0]               changed;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] key_rows;

  // Two-flop synchronizer; idles at all-ones (pulled-up, nothing pressed).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_meta <= '1;
      sync_cols <= '1;
    end else begin
      sync_meta <= col_in_n;
      sync_cols <= sync_meta;
    end
  end

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign sample    = ~sync_cols;

  // Slot counter and row sequencer. The row drive is registered from
  // row_idx, so it lags one cycle; with the two sync flops that leaves
  // SCAN_DIV-3 settle cycles before the end-of-slot sample.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_cnt    <= '0;
      row_idx     <= '0;
      row_drive_n <= 4'b1110;
    end else begin
      slot_cnt    <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) begin
        row_idx <= row_idx + 1'b1;
      end
      row_drive_n <= ~(4'b0001 << row_idx);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign sample_en[gi] = slot_wrap && (row_idx == row_idx_t'(gi));

      keypad_row_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_deb (
        .Clk      (Clk),
        .Reset    (Reset),
        .sample_en(sample_en[gi]),
        .sample   (sample),
        .key_row  (key_rows[gi]),
        .changed  (changed[gi])
      );
    end
  endgenerate

  assign key_row1   = key_rows[0];
  assign key_row2   = key_rows[1];
  assign key_row3   = key_rows[2];
  assign key_row4   = key_rows[3];
  assign key_change = |changed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix and a
// scoreboard of expected key_change events (edge number + all row vectors).
module tb_keypad_scanner;

  localparam int SD  = 16;
  localparam int DEB = 3;
  localparam int PER = 4 * SD;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] col_in_n;
  logic [3:0] row_drive_n;
  logic [7:0] key_row1, key_row2, key_row3, key_row4;
  logic       key_change;

  logic [3:0][7:0] pressed;

  typedef struct {
    int          at_edge;
    logic [31:0] rows;
  } exp_t;

  exp_t sb[$];
  int   t;
  int   checks;
  int   failures;
  int   pulses;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .col_in_n   (col_in_n),
    .row_drive_n(row_drive_n),
    .key_row1   (key_row1),
    .key_row2   (key_row2),
    .key_row3   (key_row3),
    .key_row4   (key_row4),
    .key_change (key_change)
  );

  always #5 Clk = ~Clk;

  // Physical matrix: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_in_n = 8'hFF;
    for (int r = 0; r < 4; r++) begin
      if (row_drive_n[r] === 1'b0) col_in_n = col_in_n & ~pressed[r];
    end
  end

  // One clock; any key_change pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    t++;
    #1;
    if (key_change === 1'b1) begin
      pulses++;
      $display("pulse t=%0d rows=%h", t, {key_row4, key_row3, key_row2, key_row1});
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse got=t%0d rows=%h exp=none", t,
               {key_row4, key_row3, key_row2, key_row1});
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (t === e.at_edge) else begin
          failures++;
          $error("FAIL pulse_edge got=%0d exp=%0d", t, e.at_edge);
        end
        checks++;
        assert ({key_row4, key_row3, key_row2, key_row1} === e.rows) else begin
          failures++;
          $error("FAIL pulse_rows got=%h exp=%h", {key_row4, key_row3, key_row2, key_row1}, e.rows);
        end
      end
    end
  endtask

  task automatic wait_mod(input int m, input int r);
    while (t % m != r) tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL timeout got=%0d_pending exp=0", sb.size());
    end
  endtask

  // First edge >= t+3 whose number is congruent to off modulo the row period.
  function automatic int next_sample(input int off);
    int n = t + 3;
    while (n % PER != off) n++;
    return n;
  endfunction

  task automatic check_rows(input string tag, input logic [31:0] exp_rows);
    checks++;
    assert ({key_row4, key_row3, key_row2, key_row1} === exp_rows) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, {key_row4, key_row3, key_row2, key_row1}, exp_rows);
    end
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_drv;
    int         s;
    one      = 4'b0001;
    t        = 0;
    checks   = 0;
    failures = 0;
    pulses   = 0;
    pressed  = '0;
    Reset    = 1'b1;

    // Reset state after the first edge with Reset high
    tick();
    checks++;
    assert (row_drive_n === 4'b1110) else begin
      failures++; $error("FAIL reset_drive got=%b exp=1110", row_drive_n);
    end
    checks++;
    assert (key_change === 1'b0) else begin
      failures++; $error("FAIL reset_change got=%b exp=0", key_change);
    end
    check_rows("reset_rows", 32'h0);
    tick();
    Reset = 1'b0;
    t = 0;

    // Idle: row drive walks every SD cycles, nothing changes
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (t % SD == 0 || t % SD == 1) begin
        exp_drv = ~(one << (((t - 1) / SD) % 4));
        checks++;
        assert (row_drive_n === exp_drv) else begin
          failures++; $error("FAIL row_drive t=%0d got=%b exp=%b", t, row_drive_n, exp_drv);
        end
      end
    end
    check_rows("idle_rows", 32'h0);
    $display("step idle done t=%0d", t);

    // Clean press on row 0 col 2: commit on the third row-0 sample
    wait_mod(PER, 40);
    pressed[0][2] = 1'b1;
    s = next_sample(16);
    sb.push_back('{s + 2 * PER, 32'h0000_0004});
    drain(6 * PER);
    $display("step press done t=%0d", t);

    // Release
    wait_mod(PER, 40);
    pressed[0][2] = 1'b0;
    s = next_sample(16);
    sb.push_back('{s + 2 * PER, 32'h0000_0000});
    drain(6 * PER);
    $display("step release done t=%0d", t);

    // Bounce on row 3 col 7: alternate every scan, never settles
    for (int i = 0; i < 10; i++) begin
      wait_mod(PER, 32);
      pressed[3][7] = (i % 2 == 0);
      tick();
    end
    wait_mod(PER, 30);
    check_rows("bounce_rows", 32'h0);
    wait_mod(PER, 32);
    pressed[3][7] = 1'b1;
    s = next_sample(0);
    sb.push_back('{s + 2 * PER, 32'h8000_0000});
    drain(6 * PER);
    $display("step bounce done t=%0d", t);

    // Two keys on row 1 together
    wait_mod(PER, 40);
    pressed[1][0] = 1'b1;
    pressed[1][5] = 1'b1;
    s = next_sample(32);
    sb.push_back('{s + 2 * PER, 32'h8000_2100});
    drain(6 * PER);
    $display("step multikey done t=%0d", t);

    // Single-cycle reset in the middle of a slot
    wait_mod(SD, 7);
    Reset = 1'b1;
    tick();
    check_rows("midreset_rows", 32'h0);
    checks++;
    assert (row_drive_n === 4'b1110) else begin
      failures++; $error("FAIL midreset_drive got=%b exp=1110", row_drive_n);
    end
    Reset = 1'b0;
    t = 0;
    // Held keys re-debounce from scratch: row 1 samples at 32,96,160; row 3 at 64,128,192
    sb.push_back('{32 + 2 * PER, 32'h0000_2100});
    sb.push_back('{0 + 3 * PER, 32'h8000_2100});
    drain(6 * PER);
    for (int i = 0; i < PER; i++) tick();
    check_rows("final_rows", 32'h8000_2100);
    checks++;
    assert (pulses === 6) else begin
      failures++; $error("FAIL pulse_count got=%0d exp=6", pulses);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
